// File: rtl/dds_pkg.sv
// Shared encodings and default widths for the DDS phase generator.
package dds_pkg;

    localparam int DDS_ACC_W  = 32;
    localparam int DDS_ADDR_W = 10;
    localparam int DDS_DATA_W = 8;

    typedef enum logic [1:0] {
        WAVE_SINE = 2'd0,
        WAVE_SQR  = 2'd1,
        WAVE_TRI  = 2'd2,
        WAVE_SAW  = 2'd3
    } wave_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } dds_state_e;

endpackage

// File: rtl/dds_wave_shaper.sv
// Output stage: derives square/triangle/sawtooth from the delayed phase and
// registers the selected sample alongside its valid and sync flags.
module dds_wave_shaper
    import dds_pkg::*;
#(
    parameter int DATA_W = DDS_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W:0]   phase,
    input  logic [1:0]        wave_sel,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              valid_in,
    input  logic              sync_in,
    output logic [DATA_W-1:0] wave_out,
    output logic              wave_valid,
    output logic              sync
);

    logic              msb;
    logic [DATA_W-1:0] sqr;
    logic [DATA_W-1:0] saw;
    logic [DATA_W-1:0] tri_w;
    logic [DATA_W-1:0] sample;

    // phase carries only the DATA_W+1 top address bits the shapes need
    assign msb   = phase[DATA_W];
    assign sqr   = {DATA_W{msb}};
    assign saw   = phase[DATA_W -: DATA_W];
    assign tri_w = msb ? ~phase[DATA_W-1:0] : phase[DATA_W-1:0];

    always_comb begin
        // NOTE: default first so no path through the case leaves sample unassigned (no latch).
        sample = rom_data;
        case (wave_sel_e'(wave_sel))
            WAVE_SINE: sample = rom_data;
            WAVE_SQR:  sample = sqr;
            WAVE_TRI:  sample = tri_w;
            WAVE_SAW:  sample = saw;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wave_out   <= '0;
            wave_valid <= 1'b0;
            sync       <= 1'b0;
        end else begin
            // NOTE: non-blocking for all registered state so every flop samples pre-edge values.
            wave_out   <= sample;
            wave_valid <= valid_in;
            sync       <= sync_in;
        end
    end

endmodule

// File: rtl/dds_phase_gen.sv
// Phase accumulator with wrap-synchronised retune, sine ROM addressing and a
// delay line that keeps computed waveforms aligned with ROM read latency.
module dds_phase_gen
    import dds_pkg::*;
#(
    parameter int ACC_W   = DDS_ACC_W,
    parameter int ADDR_W  = DDS_ADDR_W,
    parameter int DATA_W  = DDS_DATA_W,
    parameter int ROM_LAT = 2,
    parameter int TMO_CYC = 1048576
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ACC_W-1:0]  f_word,
    input  logic [ADDR_W-1:0] p_word,
    input  logic [1:0]        wave_sel,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] wave_out,
    output logic              wave_valid,
    output logic              sync,
    output logic [ACC_W-1:0]  f_active,
    output logic              retune_pend
);

    localparam int PH_W  = DATA_W + 1;
    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    dds_state_e        state, state_next;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  f_next;
    logic [ACC_W:0]    sum;
    logic              carry;
    logic              step;
    logic              wrap_q;
    logic [TMO_W-1:0]  tmo_cnt, tmo_next;
    logic [ADDR_W-1:0] phase;

    logic [PH_W-1:0]   ph_d    [0:ROM_LAT];
    logic [1:0]        sel_d   [0:ROM_LAT];
    logic              sync_d  [0:ROM_LAT];
    logic              valid_d [0:ROM_LAT];

    assign sum         = {1'b0, acc} + {1'b0, f_active};
    assign carry       = sum[ACC_W];
    assign phase       = acc[ACC_W-1 -: ADDR_W] + p_word;
    assign retune_pend = (state == ST_PEND);

    always_comb begin
        state_next = state;
        f_next     = f_active;
        tmo_next   = tmo_cnt;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                f_next   = f_word;
                tmo_next = '0;
                if (en) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (f_word != f_active) begin
                        state_next = ST_PEND;
                        tmo_next   = '0;
                    end
                end
            end
            ST_PEND: begin
                if (!en) begin
                    state_next = ST_IDLE;
                    tmo_next   = '0;
                end else begin
                    step = 1'b1;
                    // A stalled (zero) word never wraps, so it is replaced at once
                    if (carry || (f_active == '0) || (tmo_cnt == TMO_LAST)) begin
                        f_next     = f_word;
                        state_next = ST_RUN;
                    end else if (f_word == f_active) begin
                        state_next = ST_RUN;
                    end else begin
                        tmo_next = tmo_cnt + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            acc      <= '0;
            f_active <= '0;
            tmo_cnt  <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state    <= state_next;
            f_active <= f_next;
            tmo_cnt  <= tmo_next;
            wrap_q   <= step & carry;
            if (step) acc <= sum[ACC_W-1:0];
        end
    end

    // Each cycle outside IDLE samples the current accumulator as one live sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            // NOTE: the delay line is reset too, so in-flight samples vanish on reset.
            for (int i = 0; i <= ROM_LAT; i++) begin
                ph_d[i]    <= '0;
                sel_d[i]   <= '0;
                sync_d[i]  <= 1'b0;
                valid_d[i] <= 1'b0;
            end
        end else begin
            rom_addr   <= phase;
            ph_d[0]    <= phase[ADDR_W-1 -: PH_W];
            sel_d[0]   <= wave_sel;
            sync_d[0]  <= wrap_q && (state != ST_IDLE);
            valid_d[0] <= (state != ST_IDLE);
            for (int i = 1; i <= ROM_LAT; i++) begin
                ph_d[i]    <= ph_d[i-1];
                sel_d[i]   <= sel_d[i-1];
                sync_d[i]  <= sync_d[i-1];
                valid_d[i] <= valid_d[i-1];
            end
        end
    end

    dds_wave_shaper #(
        .DATA_W(DATA_W)
    ) u_shaper (
        .clk       (clk),
        .rst_n     (rst_n),
        .phase     (ph_d[ROM_LAT]),
        .wave_sel  (sel_d[ROM_LAT]),
        .rom_data  (rom_data),
        .valid_in  (valid_d[ROM_LAT]),
        .sync_in   (sync_d[ROM_LAT]),
        .wave_out  (wave_out),
        .wave_valid(wave_valid),
        .sync      (sync)
    );

endmodule

// File: tb/tb_dds_phase_gen.sv
// Scoreboard bench for dds_phase_gen: a behavioural model queues expected
// samples, a monitor pops them when the DUT presents wave_valid.
module tb_dds_phase_gen;

    localparam int ACC_W   = 32;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int ROM_LAT = 2;
    localparam int TMO_CYC = 100;
    localparam longint ACC_MOD = longint'(1) << ACC_W;
    localparam logic [ACC_W-1:0] F26 = 32'h0400_0000;
    localparam logic [ACC_W-1:0] F27 = 32'h0800_0000;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [ACC_W-1:0]  f_word;
    logic [ADDR_W-1:0] p_word;
    logic [1:0]        wave_sel;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] wave_out;
    logic              wave_valid;
    logic              sync;
    logic [ACC_W-1:0]  f_active;
    logic              retune_pend;

    dds_phase_gen #(
        .ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .ROM_LAT(ROM_LAT), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .f_word(f_word), .p_word(p_word),
        .wave_sel(wave_sel), .rom_addr(rom_addr), .rom_data(rom_data),
        .wave_out(wave_out), .wave_valid(wave_valid), .sync(sync),
        .f_active(f_active), .retune_pend(retune_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stand-in ROM contents: any address-distinguishing pattern will do
    function automatic logic [DATA_W-1:0] rom_fn(input int a);
        return DATA_W'(a * 37 + (a >> 3) + 11);
    endfunction

    function automatic logic [DATA_W-1:0] exp_wave(input int ph, input int sel);
        int half = 1 << (ADDR_W - 1);
        int top  = (1 << DATA_W) - 1;
        int t    = (ph >> (ADDR_W - 1 - DATA_W)) % (1 << DATA_W);
        case (sel)
            0:       return rom_fn(ph);
            1:       return (ph >= half) ? DATA_W'(top) : '0;
            2:       return DATA_W'((ph >= half) ? top - t : t);
            default: return DATA_W'(ph >> (ADDR_W - DATA_W));
        endcase
    endfunction

    logic [DATA_W-1:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_fn(int'(rom_addr));
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    typedef struct {
        int                due;
        logic [DATA_W-1:0] wave;
        bit                sync;
    } exp_t;

    exp_t   sb_q [$];
    exp_t   e_cur;
    int     cyc = 0;
    longint m_acc = 0, m_f = 0, m_sum;
    bit     m_on = 0, m_pend = 0, m_wrapped = 0, m_wrap;
    int     m_wait = 0, m_addr = 0, m_ph;

    // Reference model: phase = top address bits + offset; retunes land on wraps
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_acc = 0; m_f = 0; m_on = 0; m_pend = 0; m_wrapped = 0;
            m_wait = 0; m_addr = 0;
            sb_q.delete();
        end else begin
            m_ph   = int'(((m_acc >> (ACC_W - ADDR_W)) + longint'(p_word)) % (1 << ADDR_W));
            m_addr = m_ph;
            if (m_on)
                sb_q.push_back('{due: cyc + ROM_LAT + 1, wave: exp_wave(m_ph, int'(wave_sel)),
                                 sync: m_wrapped});
            if (!m_on) begin
                m_f = longint'(f_word); m_pend = 0; m_wrapped = 0; m_on = en;
            end else if (!en) begin
                m_on = 0; m_pend = 0; m_wrapped = 0;
            end else begin
                m_sum     = m_acc + m_f;
                m_wrap    = (m_sum >= ACC_MOD);
                m_acc     = m_sum % ACC_MOD;
                m_wrapped = m_wrap;
                if (!m_pend) begin
                    if (longint'(f_word) != m_f) begin m_pend = 1; m_wait = 0; end
                end else if (m_wrap || m_f == 0 || m_wait == TMO_CYC - 1) begin
                    m_f = longint'(f_word); m_pend = 0;
                end else if (longint'(f_word) == m_f) begin
                    m_pend = 0;
                end else begin
                    m_wait++;
                end
            end
        end
    end

    int last_sync = -1;
    int sync_period = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e_cur = sb_q.pop_front();
                check("wave_valid", wave_valid, 1);
                check("wave_out", wave_out, e_cur.wave);
                check("sync", sync, e_cur.sync);
            end else begin
                check("wave_valid_idle", wave_valid, 0);
            end
            if (wave_valid && sync) begin
                sync_period = cyc - last_sync;
                last_sync   = cyc;
            end
            check("f_active", f_active, m_f);
            check("retune_pend", retune_pend, m_pend);
            check("rom_addr", rom_addr, m_addr);
        end
    end

    task automatic wait_sync();
        int n = 0;
        do begin @(negedge clk); n++; end while (!(wave_valid && sync) && n < 2000);
        check("sync_seen", wave_valid & sync, 1);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_wave_out"}, wave_out, 0);
        check({tag, "_wave_valid"}, wave_valid, 0);
        check({tag, "_sync"}, sync, 0);
        check({tag, "_f_active"}, f_active, 0);
        check({tag, "_retune_pend"}, retune_pend, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; en = 1'b0; f_word = '0; p_word = '0; wave_sel = 2'd3;
        repeat (3) @(negedge clk);
        #1 check_zero_outputs("reset");
        @(negedge clk); #2 rst_n = 1'b1;

        // Start-up from IDLE with 2^26: period 64, first sample ROM_LAT+2 after en is seen
        @(negedge clk);
        f_word = F26; en = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!wave_valid && n < 50);
        check("first_valid_lat", n, ROM_LAT + 3);
        check("f_active_from_idle", f_active, F26);
        wait_sync();
        wait_sync();
        check("period_2p26", sync_period, 64);

        // Retune issued 20 cycles after the wrap; sync trails the wrap by the pipeline
        repeat (20 - (ROM_LAT + 3)) @(negedge clk);
        f_word = F27;
        n = 0;
        @(negedge clk);
        while (retune_pend && n < 500) begin n++; @(negedge clk); end
        check("retune_pend_len", n, 44);
        check("f_active_on_wrap", f_active, F27);
        wait_sync();
        check("period_during_retune", sync_period, 64);
        wait_sync();
        check("period_after_retune", sync_period, 32);

        // Timeout: a word of 1 never wraps in TMO_CYC cycles, so the retune is forced
        f_word = 32'd1;
        n = 0;
        do begin @(negedge clk); n++; end while ((retune_pend || f_active != 32'd1) && n < 200);
        check("slow_word_applied", f_active, 1);
        f_word = F26;
        n = 0;
        @(negedge clk);
        while (retune_pend && n < 4 * TMO_CYC) begin n++; @(negedge clk); end
        check("timeout_len", n, TMO_CYC);
        check("timeout_apply", f_active, F26);

        // Square wave duty over one full period
        wave_sel = 2'd1;
        repeat (ROM_LAT + 3) @(negedge clk);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (wave_valid && wave_out == 8'hFF) n++;
        end
        check("square_duty", n, 32);

        wave_sel = 2'd2;
        repeat (100) @(negedge clk);
        wave_sel = 2'd3; p_word = 10'd256;
        repeat (100) @(negedge clk);
        wave_sel = 2'd0; p_word = 10'd0;
        repeat (100) @(negedge clk);

        // en drop while a retune is pending
        f_word = F27;
        n = 0;
        do begin @(negedge clk); n++; end while (!retune_pend && n < 10);
        check("pend_before_drop", retune_pend, 1);
        en = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (wave_valid && n < 50);
        check("valid_fall_lat", n, ROM_LAT + 3);
        check("pend_discarded", retune_pend, 0);
        repeat (5) @(negedge clk);
        en = 1'b1;
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("midrun_reset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(99) < 2) en = ~en;
            if ($urandom_range(99) < 4) begin
                case ($urandom_range(5))
                    0: f_word = F26;
                    1: f_word = F27;
                    2: f_word = $urandom;
                    3: f_word = '0;
                    4: f_word = 32'd1 << $urandom_range(30, 22);
                    default: f_word = f_word ^ 32'h0000_0100;
                endcase
            end
            if ($urandom_range(99) < 2) p_word = ADDR_W'($urandom);
            if ($urandom_range(99) < 3) wave_sel = 2'($urandom_range(3));
        end
        en = 1'b0;
        repeat (ROM_LAT + 5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
